// File: rtl/stack_calc_core.sv
// Stack-machine calculator core: WIDTH-bit words, DEPTH-entry register stack,
// valid/ready opcode intake, sticky first-error code and a two-cycle MUL.
module stack_calc_core #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [3:0]                 opcode,
    input  logic [WIDTH-1:0]           operand,
    output logic [WIDTH-1:0]           top,
    output logic [WIDTH-1:0]           second,
    output logic [$clog2(DEPTH):0]     depth,
    output logic [2*WIDTH-1:0]         out_reg,
    output logic                       carry,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic                       fsm_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    typedef enum logic {IDLE = 1'b0, MUL2 = 1'b1} state_t;

    // Handshake: an opcode is consumed on a rising edge where op_valid && op_ready;
    // while op_ready is low the source must hold op_valid and its payload.

    state_t             state, state_nx;
    logic [WIDTH-1:0]   stk [DEPTH];
    logic [WIDTH-1:0]   mul_lo, mul_lo_nx;
    logic [AW-1:0]      i0, i1, ip;
    logic               op_fire, underflow, overflow, fault;
    logic [1:0]         min_req;
    logic               grows;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic               wa_en, wb_en;
    logic [AW-1:0]      wa_idx, wb_idx;
    logic [WIDTH-1:0]   wa_data, wb_data;
    logic [DW-1:0]      depth_nx;
    logic               carry_nx, outl_en, outh_en, errclr;

    assign i0 = AW'(depth - DW'(1));
    assign i1 = AW'(depth - DW'(2));
    assign ip = AW'(depth);

    assign top       = (depth != '0)     ? stk[i0] : '0;
    assign second    = (depth >= DW'(2)) ? stk[i1] : '0;
    assign op_ready  = (state == IDLE);
    assign fsm_state = state;

    assign sum  = {1'b0, second} + {1'b0, top};
    assign diff = {1'b0, second} - {1'b0, top};
    assign prod = {{WIDTH{1'b0}}, second} * {{WIDTH{1'b0}}, top};

    always_comb begin
        min_req = 2'd0;
        grows   = 1'b0;
        case (opcode)
            4'h1:                   grows = 1'b1;
            4'h2, 4'h3, 4'h4, 4'h7: min_req = 2'd1;
            4'h6: begin             min_req = 2'd1; grows = 1'b1; end
            4'h5, 4'h8, 4'h9, 4'hA,
            4'hB, 4'hC, 4'hD:       min_req = 2'd2;
            default: ;
        endcase
        op_fire   = op_valid && op_ready;
        underflow = depth < DW'(min_req);
        overflow  = grows && (depth == DW'(DEPTH));
        fault     = op_fire && (underflow || overflow);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (op_fire && !fault && opcode == 4'hD) state_nx = MUL2;
            MUL2: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wa_en     = 1'b0;
        wa_idx    = '0;
        wa_data   = '0;
        wb_en     = 1'b0;
        wb_idx    = '0;
        wb_data   = '0;
        depth_nx  = depth;
        carry_nx  = carry;
        outl_en   = 1'b0;
        outh_en   = 1'b0;
        errclr    = 1'b0;
        mul_lo_nx = mul_lo;
        if (state == MUL2) begin
            wa_en    = 1'b1;
            wa_idx   = ip;
            wa_data  = mul_lo;
            depth_nx = depth + DW'(1);
        end else if (op_fire && !fault) begin
            case (opcode)
                4'h1: begin wa_en = 1'b1; wa_idx = ip; wa_data = operand; depth_nx = depth + DW'(1); end
                4'h2: depth_nx = depth - DW'(1);
                4'h3: outl_en = 1'b1;
                4'h4: outh_en = 1'b1;
                4'h5: begin
                    wa_en = 1'b1; wa_idx = i0; wa_data = second;
                    wb_en = 1'b1; wb_idx = i1; wb_data = top;
                end
                4'h6: begin wa_en = 1'b1; wa_idx = ip; wa_data = top; depth_nx = depth + DW'(1); end
                4'h7: begin wa_en = 1'b1; wa_idx = i0; wa_data = ~top; end
                4'h8: begin
                    wa_en = 1'b1; wa_idx = i1; wa_data = sum[WIDTH-1:0];
                    carry_nx = sum[WIDTH]; depth_nx = depth - DW'(1);
                end
                4'h9: begin
                    wa_en = 1'b1; wa_idx = i1; wa_data = diff[WIDTH-1:0];
                    carry_nx = diff[WIDTH]; depth_nx = depth - DW'(1);
                end
                4'hA: begin wa_en = 1'b1; wa_idx = i1; wa_data = second & top; depth_nx = depth - DW'(1); end
                4'hB: begin wa_en = 1'b1; wa_idx = i1; wa_data = second | top; depth_nx = depth - DW'(1); end
                4'hC: begin wa_en = 1'b1; wa_idx = i1; wa_data = second ^ top; depth_nx = depth - DW'(1); end
                // High half lands now; low half is pushed from mul_lo in MUL2.
                4'hD: begin
                    wa_en = 1'b1; wa_idx = i1; wa_data = prod[2*WIDTH-1:WIDTH];
                    depth_nx = depth - DW'(1); mul_lo_nx = prod[WIDTH-1:0];
                end
                4'hE: depth_nx = '0;
                4'hF: errclr = 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries at or above depth are never visible.
    always_ff @(posedge clk) begin
        if (wa_en) stk[wa_idx] <= wa_data;
        if (wb_en) stk[wb_idx] <= wb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            depth    <= '0;
            out_reg  <= '0;
            carry    <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
            mul_lo   <= '0;
        end else begin
            state  <= state_nx;
            depth  <= depth_nx;
            carry  <= carry_nx;
            mul_lo <= mul_lo_nx;
            if (outl_en) out_reg[WIDTH-1:0]       <= top;
            if (outh_en) out_reg[2*WIDTH-1:WIDTH] <= top;
            if (fault) begin
                err <= 1'b1;
                if (err_code == 2'b00) err_code <= underflow ? 2'b01 : 2'b10;
            end else if (errclr) begin
                err      <= 1'b0;
                err_code <= 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_stack_calc_core.sv
// Directed bench for stack_calc_core: a 4-bit/8-deep instance and an
// 8-bit/16-deep instance, checked against hand-computed values.
module tb_stack_calc_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    // 4-bit instance
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  opcode = 4'h0;
    logic [3:0]  operand = 4'h0;
    logic [3:0]  top, second;
    logic [3:0]  depth;
    logic [7:0]  out_reg;
    logic        carry, err, fsm_state;
    logic [1:0]  err_code;

    // 8-bit instance
    logic        op_valid8 = 1'b0;
    logic        op_ready8;
    logic [3:0]  opcode8 = 4'h0;
    logic [7:0]  operand8 = 8'h0;
    logic [7:0]  top8, second8;
    logic [4:0]  depth8;
    logic [15:0] out_reg8;
    logic        carry8, err8, fsm_state8;
    logic [1:0]  err_code8;

    always #5 clk = ~clk;

    stack_calc_core #(.WIDTH(4), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .operand(operand), .top(top), .second(second),
        .depth(depth), .out_reg(out_reg), .carry(carry), .err(err),
        .err_code(err_code), .fsm_state(fsm_state)
    );

    stack_calc_core #(.WIDTH(8), .DEPTH(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid8), .op_ready(op_ready8),
        .opcode(opcode8), .operand(operand8), .top(top8), .second(second8),
        .depth(depth8), .out_reg(out_reg8), .carry(carry8), .err(err8),
        .err_code(err_code8), .fsm_state(fsm_state8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one opcode for a single accepting edge; returns at the following negedge.
    task automatic issue(input logic [3:0] op, input logic [3:0] val);
        int k = 0;
        @(negedge clk);
        while (!op_ready && k < 10) begin @(negedge clk); k++; end
        if (!op_ready) chk("ready_timeout", 32'(op_ready), 32'd1);
        op_valid = 1'b1; opcode = op; operand = val;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] val);
        int k = 0;
        @(negedge clk);
        while (!op_ready8 && k < 10) begin @(negedge clk); k++; end
        if (!op_ready8) chk("ready8_timeout", 32'(op_ready8), 32'd1);
        op_valid8 = 1'b1; opcode8 = op; operand8 = val;
        @(negedge clk);
        op_valid8 = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_top", 32'(top), 32'd0);
        chk("rst_second", 32'(second), 32'd0);
        chk("rst_out_reg", 32'(out_reg), 32'd0);
        chk("rst_err", 32'({err, err_code, carry}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(op_ready), 32'd1);

        // ADD with and without carry
        issue(4'h1, 4'h3); issue(4'h1, 4'h5); issue(4'h8, 4'h0);
        chk("add_top", 32'(top), 32'h8);
        chk("add_depth", 32'(depth), 32'd1);
        chk("add_carry", 32'(carry), 32'd0);
        issue(4'h1, 4'h9); issue(4'h8, 4'h0);
        chk("addc_top", 32'(top), 32'h1);
        chk("addc_carry", 32'(carry), 32'd1);

        // MUL 7*6 = 0x2A
        issue(4'hE, 4'h0);
        chk("clr_depth", 32'(depth), 32'd0);
        issue(4'h1, 4'h7); issue(4'h1, 4'h6); issue(4'hD, 4'h0);
        chk("mul_ready_low", 32'(op_ready), 32'd0);
        @(negedge clk);
        chk("mul_ready_back", 32'(op_ready), 32'd1);
        chk("mul_top", 32'(top), 32'hA);
        chk("mul_second", 32'(second), 32'h2);
        chk("mul_depth", 32'(depth), 32'd2);

        // Overflow at full stack
        issue(4'hE, 4'h0);
        for (int i = 1; i <= 8; i++) issue(4'h1, 4'(i));
        chk("full_depth", 32'(depth), 32'd8);
        issue(4'h1, 4'hF);
        chk("ovf_depth", 32'(depth), 32'd8);
        chk("ovf_top", 32'(top), 32'h8);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_code", 32'(err_code), 32'd2);
        issue(4'h2, 4'h0);
        chk("pop_top", 32'(top), 32'h7);
        chk("pop_depth", 32'(depth), 32'd7);
        issue(4'hF, 4'h0);
        chk("errclr", 32'({err, err_code}), 32'd0);

        // Underflow, first error held
        issue(4'hE, 4'h0);
        issue(4'h2, 4'h0);
        chk("udf_code", 32'(err_code), 32'd1);
        chk("udf_depth", 32'(depth), 32'd0);
        issue(4'h1, 4'h2);
        chk("held_code", 32'(err_code), 32'd1);
        chk("held_depth", 32'(depth), 32'd1);
        chk("held_top", 32'(top), 32'h2);

        // OUTH/OUTL, SUB with borrow, then SWAP/NOT/XOR/DUP
        issue(4'hE, 4'h0); issue(4'hF, 4'h0);
        issue(4'h1, 4'hC); issue(4'h4, 4'h0); issue(4'h1, 4'h3); issue(4'h3, 4'h0);
        chk("out_reg", 32'(out_reg), 32'hC3);
        issue(4'h1, 4'h1); issue(4'h1, 4'h2); issue(4'h9, 4'h0);
        chk("sub_top", 32'(top), 32'hF);
        chk("sub_carry", 32'(carry), 32'd1);
        chk("sub_second", 32'(second), 32'h3);
        chk("sub_depth", 32'(depth), 32'd3);
        issue(4'h5, 4'h0);
        chk("swap", 32'({top, second}), 32'h3F);
        issue(4'h7, 4'h0);
        chk("not_top", 32'(top), 32'hC);
        issue(4'hC, 4'h0);
        chk("xor", 32'({top, second, depth}), 32'h3C2);
        issue(4'h6, 4'h0);
        chk("dup", 32'({top, second, depth}), 32'h333);

        // Reset during MUL2 aborts with no partial push
        issue(4'h1, 4'h7); issue(4'h1, 4'h6); issue(4'hD, 4'h0);
        chk("abort_in_mul2", 32'(fsm_state), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_depth", 32'(depth), 32'd0);
        chk("abort_top", 32'(top), 32'd0);
        chk("abort_out_reg", 32'(out_reg), 32'd0);
        chk("abort_carry", 32'(carry), 32'd0);
        chk("abort_ready", 32'(op_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_push", 32'(depth), 32'd0);

        // 8-bit/16-deep instance
        issue8(4'h1, 8'd200); issue8(4'h1, 8'd100); issue8(4'h8, 8'd0);
        chk("w8_add_top", 32'(top8), 32'd44);
        chk("w8_add_carry", 32'(carry8), 32'd1);
        chk("w8_add_depth", 32'(depth8), 32'd1);
        issue8(4'h1, 8'd16); issue8(4'h1, 8'd17); issue8(4'hD, 8'd0);
        @(negedge clk);
        chk("w8_mul", 32'({top8, second8}), 32'h1001);
        chk("w8_mul_depth", 32'(depth8), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
